// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, drives
//   the synchronous (1-cycle latency) instruction SRAM and hands {ce, pc} to
//   decode. Redirects come from two places: the branch bus resolved in decode
//   and the exception/ERET flush. A branch that resolves while the PC is
//   frozen is parked in a one-entry pending buffer and used on the next
//   advance.
//
// Parameters
//   RESET_PC         first fetch address after reset
//
// Ports
//   clk              clock
//   rst              synchronous, active-high reset
//   stall[5:0]       pipeline stall bus; bit 0 = 1 freezes the PC
//   flush            one-cycle exception/ERET redirect pulse
//   new_pc[31:0]     redirect target, valid with flush
//   br_bus[32:0]     {br_e, br_addr} from decode
//   if_to_id_bus     {ce, pc} to decode
//   inst_sram_en     instruction SRAM enable (= ce)
//   inst_sram_wen    byte write enables, always 4'b0000
//   inst_sram_addr   fetch address (= pc)
//   inst_sram_wdata  write data, always 0
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic [32:0] br_bus,
  output logic [32:0] if_to_id_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata
);

  typedef enum logic {
    PEND_IDLE = 1'b0,
    PEND_HELD = 1'b1
  } pend_state_e;

  // Reset parks the PC one word before the boot vector so that the first
  // ordinary +4 advance after reset release fetches RESET_PC itself.
  localparam logic [31:0] PC_RESET_VAL = RESET_PC - 32'd4;

  pend_state_e pend_state_q;
  logic [31:0] pc_q;
  logic [31:0] pend_addr_q;
  logic        ce_q;

  logic [31:0] pc_d;
  logic        br_e;
  logic [31:0] br_addr;
  logic        pc_stop;
  logic        advance;
  logic        pend_valid;

  // Only bit 0 of the stall bus concerns the PC; the rest belong to later
  // pipeline registers and are deliberately ignored here.
  logic        unused_stall;
  assign unused_stall = ^stall[5:1];

  assign br_e       = br_bus[32];
  assign br_addr    = br_bus[31:0];
  assign pc_stop    = stall[0];
  assign pend_valid = (pend_state_q == PEND_HELD);

  // A flush redirects even while the PC is frozen.
  assign advance = flush | ~pc_stop;

  // Next fetch address, strict priority. A live branch outranks the parked
  // one because it is younger; flush outranks everything and kills both.
  // Targets are passed through as-is: alignment faults are raised downstream.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (flush) begin
      pc_d = new_pc;
    end else if (br_e) begin
      pc_d = br_addr;
    end else if (pend_valid) begin
      pc_d = pend_addr_q;
    end
  end

  // PC, fetch-enable and pending-branch buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= PC_RESET_VAL;
      ce_q         <= 1'b0;
      pend_state_q <= PEND_IDLE;
      pend_addr_q  <= 32'd0;
    end else if (advance) begin
      // Any advance consumes (or, on flush, discards) a parked target.
      pc_q         <= pc_d;
      ce_q         <= 1'b1;
      pend_state_q <= PEND_IDLE;
    end else if (br_e) begin
      // Frozen PC and no flush: remember the branch. A newer branch while
      // still frozen simply overwrites the older target.
      pend_state_q <= PEND_HELD;
      pend_addr_q  <= br_addr;
    end
  end

  // When frozen, pc_q holds, so the SRAM simply re-reads the same word.
  assign inst_sram_en    = ce_q;
  assign inst_sram_addr  = pc_q;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'd0;
  assign if_to_id_bus    = {ce_q, pc_q};

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam logic [31:0] RP  = 32'hBFC0_0000;
  localparam logic [31:0] RPM = 32'hBFBF_FFFC;  // RESET_PC - 4

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall = 6'd0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = 32'd0;
  logic [32:0] br_bus = 33'd0;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RP)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .new_pc         (new_pc),
    .br_bus         (br_bus),
    .if_to_id_bus   (if_to_id_bus),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_wen  (inst_sram_wen),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata)
  );

  typedef struct {
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        br_e;
    logic [31:0] br_addr;
    logic        exp_en;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [5:0] st, input logic fl,
                     input logic [31:0] np, input logic be, input logic [31:0] ba,
                     input logic een, input logic [31:0] ead);
    vec_t v;
    v.rst = r; v.stall = st; v.flush = fl; v.new_pc = np;
    v.br_e = be; v.br_addr = ba; v.exp_en = een; v.exp_addr = ead;
    vecs.push_back(v);
  endtask

  // Apply one cycle of inputs, clock once, and sample 1 ns after the edge.
  task automatic step(input logic r, input logic [5:0] st, input logic fl,
                      input logic [31:0] np, input logic be, input logic [31:0] ba);
    rst = r; stall = st; flush = fl; new_pc = np; br_bus = {be, ba};
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int idx,
                       input logic een, input logic [31:0] ead);
    n_checks++;
    if (inst_sram_addr !== ead) begin
      n_fail++;
      $display("FAIL %s[%0d] addr: got %08h want %08h", tag, idx, inst_sram_addr, ead);
    end
    n_checks++;
    if (inst_sram_en !== een) begin
      n_fail++;
      $display("FAIL %s[%0d] en: got %0b want %0b", tag, idx, inst_sram_en, een);
    end
    n_checks++;
    if (if_to_id_bus !== {een, ead}) begin
      n_fail++;
      $display("FAIL %s[%0d] if_to_id_bus: got %09h want %09h", tag, idx, if_to_id_bus, {een, ead});
    end
    n_checks++;
    if (inst_sram_wen !== 4'b0000 || inst_sram_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL %s[%0d] write: got wen=%0h wdata=%08h want 0/0", tag, idx,
               inst_sram_wen, inst_sram_wdata);
    end
  endtask

  // Reference model: PC as a number, fetch enable, and the parked branch
  // targets held in a queue of at most one element.
  logic [31:0] m_pc;
  logic        m_ce;
  logic [31:0] m_pend[$];

  task automatic model(input logic r, input logic st0, input logic fl,
                       input logic [31:0] np, input logic be, input logic [31:0] ba);
    if (r) begin
      m_pc = RP - 32'd4;
      m_ce = 1'b0;
      m_pend.delete();
    end else if (fl) begin
      m_pc = np; m_ce = 1'b1; m_pend.delete();
    end else if (!st0) begin
      if (be)                   m_pc = ba;
      else if (m_pend.size()>0) m_pc = m_pend[0];
      else                      m_pc = m_pc + 32'd4;
      m_ce = 1'b1;
      m_pend.delete();
    end else if (be) begin
      m_pend.delete();
      m_pend.push_back(ba);
    end
  endtask

  initial begin
    // ---------------- directed table ----------------
    // reset start
    add(1, 0, 0, 0, 0, 0,               0, RPM);
    add(1, 0, 0, 0, 0, 0,               0, RPM);
    add(1, 0, 0, 0, 0, 0,               0, RPM);
    add(0, 0, 0, 0, 0, 0,               1, 32'hBFC0_0000);
    add(0, 0, 0, 0, 0, 0,               1, 32'hBFC0_0004);
    // taken branch with pc=BFC00004
    add(0, 0, 0, 0, 1, 32'hBFC0_0100,   1, 32'hBFC0_0100);
    add(0, 0, 0, 0, 0, 0,               1, 32'hBFC0_0104);
    // move to BFC00010, stall two cycles
    add(0, 0, 0, 0, 1, 32'hBFC0_0010,   1, 32'hBFC0_0010);
    add(0, 6'b000011, 0, 0, 0, 0,       1, 32'hBFC0_0010);
    add(0, 6'b000011, 0, 0, 0, 0,       1, 32'hBFC0_0010);
    add(0, 0, 0, 0, 0, 0,               1, 32'hBFC0_0014);
    // stall[5:1] alone does not freeze the PC
    add(0, 6'b111110, 0, 0, 0, 0,       1, 32'hBFC0_0018);
    // branch arrives while stalled, applied on release
    add(0, 6'b000001, 0, 0, 1, 32'hBFC0_0200, 1, 32'hBFC0_0018);
    add(0, 6'b000001, 0, 0, 0, 0,       1, 32'hBFC0_0018);
    add(0, 6'b000001, 0, 0, 0, 0,       1, 32'hBFC0_0018);
    add(0, 0, 0, 0, 0, 0,               1, 32'hBFC0_0200);
    add(0, 0, 0, 0, 0, 0,               1, 32'hBFC0_0204);
    // flush and branch together while stalled: flush wins, branch dropped
    add(0, 6'b000001, 1, 32'hBFC0_0380, 1, 32'hBFC0_0040, 1, 32'hBFC0_0380);
    add(0, 6'b000001, 0, 0, 0, 0,       1, 32'hBFC0_0380);
    add(0, 0, 0, 0, 0, 0,               1, 32'hBFC0_0384);
    add(0, 0, 0, 0, 0, 0,               1, 32'hBFC0_0388);
    // misaligned target passes through unchanged
    add(0, 0, 0, 0, 1, 32'h0000_0003,   1, 32'h0000_0003);
    add(0, 0, 0, 0, 0, 0,               1, 32'h0000_0007);
    // wrap-around
    add(0, 0, 0, 0, 1, 32'hFFFF_FFFC,   1, 32'hFFFF_FFFC);
    add(0, 0, 0, 0, 0, 0,               1, 32'h0000_0000);
    add(0, 0, 0, 0, 0, 0,               1, 32'h0000_0004);
    // reset while a branch is pending
    add(0, 6'b000001, 0, 0, 1, 32'h1234_5678, 1, 32'h0000_0004);
    add(1, 6'b000001, 0, 0, 0, 0,       0, RPM);
    add(0, 0, 0, 0, 0, 0,               1, 32'hBFC0_0000);
    add(0, 0, 0, 0, 0, 0,               1, 32'hBFC0_0004);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].new_pc,
           vecs[i].br_e, vecs[i].br_addr);
      check("table", i, vecs[i].exp_en, vecs[i].exp_addr);
    end

    // ---------------- hand-written pending corner cases ----------------
    // newer branch overwrites a pending one
    step(0, 6'b000001, 0, 0, 1, 32'h0000_1000); check("overwrite", 0, 1, 32'hBFC0_0004);
    step(0, 6'b000001, 0, 0, 1, 32'h0000_2000); check("overwrite", 1, 1, 32'hBFC0_0004);
    step(0, 0, 0, 0, 0, 0);                     check("overwrite", 2, 1, 32'h0000_2000);
    step(0, 0, 0, 0, 0, 0);                     check("overwrite", 3, 1, 32'h0000_2004);
    // live branch in the releasing cycle beats the pending one
    step(0, 6'b000001, 0, 0, 1, 32'h0000_3000); check("livebr", 0, 1, 32'h0000_2004);
    step(0, 0, 0, 0, 1, 32'h0000_4000);         check("livebr", 1, 1, 32'h0000_4000);
    step(0, 0, 0, 0, 0, 0);                     check("livebr", 2, 1, 32'h0000_4004);
    // flush while pending discards the pending target
    step(0, 6'b000001, 0, 0, 1, 32'h0000_5000); check("flushpend", 0, 1, 32'h0000_4004);
    step(0, 6'b000001, 1, 32'h0000_6000, 0, 0); check("flushpend", 1, 1, 32'h0000_6000);
    step(0, 6'b000001, 0, 0, 0, 0);             check("flushpend", 2, 1, 32'h0000_6000);
    step(0, 0, 0, 0, 0, 0);                     check("flushpend", 3, 1, 32'h0000_6004);

    // ---------------- randomized against the model ----------------
    step(1, 0, 0, 0, 0, 0);
    model(1, 0, 0, 0, 0, 0);
    check("rand_rst", 0, m_ce, m_pc);
    for (int k = 0; k < 3000; k++) begin
      logic        r, st0, fl, be;
      logic [5:0]  st;
      logic [31:0] np, ba;
      r   = ($urandom_range(99) < 2);
      st0 = ($urandom_range(99) < 40);
      fl  = ($urandom_range(99) < 10);
      be  = ($urandom_range(99) < 25);
      st  = {$urandom_range(31) > 15 ? 5'h1F : 5'h00, st0};
      np  = $urandom;
      ba  = $urandom;
      step(r, st, fl, np, be, ba);
      model(r, st0, fl, np, be, ba);
      check("rand", k, m_ce, m_pc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
